can_bit_stuffer: RTL and testbench
==================================

# can_bit_stuffer

- Sits directly downstream of the CAN frame generator and drives the physical `can_tx` pin.
- Accepts raw, unstuffed frame bits one at a time over a valid/ready handshake.
- Paces them onto the line at the nominal CAN bit rate.
- Inserts a complementary stuff bit after every five consecutive identical bits inside the stuffed region (SOF through CRC).
- Holds the line recessive whenever no bit is offered.

## Interface
- `BIT_PERIOD`, default 100: clk cycles per CAN bit (500 kbit/s at 50 MHz); legal range 4..65535.
- `clk` in 1: system clock; all logic rising-edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: `in_bit`/`in_stuff_en` hold a bit to transmit.
- `in_bit` in 1: raw frame bit (0 = dominant).
- `in_stuff_en` in 1: bit lies in the stuffed region (SOF..last CRC bit).
- `in_ready` out 1: one-cycle pulse at a bit boundary when an input bit can be taken; transfer = `in_valid && in_ready`.
- `can_tx` out 1: line bit, registered.
- `bit_strobe` out 1: one-cycle pulse coincident with every `can_tx` update.
- `stuff_flag` out 1: high for the whole bit time when `can_tx` carries a stuff bit.
- `stuff_cnt` out 8: number of stuff bits inserted, saturating at 255 (see Configuration).

## Operation
- Bit timer counts 0..BIT_PERIOD-1, free-running after reset.
- `tick` = (timer == BIT_PERIOD-1).
- FSM states:
  - **IDLE**: no frame bit in flight, line recessive.
  - **DATA**: last emitted bit came from input.
  - **STUFF**: stuff bit on line.
- Registers:
  - `last_bit`: last line bit.
  - `run`: 3-bit count of consecutive identical line bits inside the stuffed region.
  - `stuff_pend`: a stuff bit is owed.
- At each tick, in priority order:
  - **`stuff_pend`**:
    - `can_tx` <= ~`last_bit`; `last_bit` <= that value; `run` <= 1; `stuff_pend` <= 0; state STUFF.
    - `in_ready` stays low.
  - **`in_valid`**:
    - `in_ready` = 1 (combinationally on tick); `can_tx` <= `in_bit`; state DATA.
    - If `in_stuff_en`: `run` <= (`in_bit` == `last_bit` && `run` != 0) ? `run`+1 : 1. If the new `run` == 5, then `stuff_pend` <= 1.
    - If `in_stuff_en` is 0: `run` <= 0.
  - **Otherwise**:
    - `in_ready` = 1, but no transfer; `can_tx` <= 1; `run` <= 0; `last_bit` <= 1; state IDLE.
- A pending stuff bit is always emitted, even if `in_valid` or `in_stuff_en` has dropped. This covers a stuff bit after the final CRC bit.
- Stuff bits count as the first bit of a new run and can themselves start a stuffing sequence.
- `in_ready` is never high off-tick; bits offered off-tick wait.

## Timing
- Reset values:
  - `can_tx`=1, `bit_strobe`=0, `in_ready`=0, `stuff_flag`=0, `stuff_cnt`=0.
  - timer=0, `run`=0, `last_bit`=1, `stuff_pend`=0, state IDLE.
- First tick occurs BIT_PERIOD-1 cycles after reset release.
- Latency: a bit accepted in tick cycle t appears on `can_tx` at t+1, together with the `bit_strobe` pulse; it is held for exactly BIT_PERIOD cycles.
- `bit_strobe` pulses every BIT_PERIOD cycles, including recessive idle bits.
- Each tick produces exactly one `can_tx` update; stuff insertion costs one full bit time, during which upstream is stalled.
- Reset mid-frame or mid-stuff:
  - Everything returns to reset values on the next edge.
  - Any pending stuff bit is discarded.
  - Line goes recessive on that same edge.

## Configuration
- `CAN_STUFF_STATS_EN` defined:
  - `stuff_cnt` increments on every inserted stuff bit, saturating at 255.
  - Cleared only by reset.
- Macro undefined: `stuff_cnt` is tied to 0 and no counter logic is built. Port list is unchanged.

## Structure
- Shared package `can_pkg`:
  - `CAN_RECESSIVE`=1'b1 and `CAN_DOMINANT`=1'b0.
  - `CAN_STUFF_RUN`=5.
  - Default `BIT_PERIOD`.
  - Enum `stuff_state_t` {IDLE, DATA, STUFF}.
- Sub-module `can_bit_timer`: parameterised prescaler producing `tick`. It will be reused by the future CAN RX sampler.

## Test plan
- BIT_PERIOD=8; stream 0,0,0,0,0,1 with `in_stuff_en`=1 -> line 0,0,0,0,0,1(stuff, `stuff_flag`=1),1. `in_ready` low for the stuff slot; `stuff_cnt`=1.
- Ten 1s with stuff_en=1 -> line 1×5,0,1×5,0. Second stuff bit is inserted after the final input bit with `in_valid` low; `stuff_cnt`=2.
- Seven 0s with `in_stuff_en`=0 -> seven 0s, no stuff, `stuff_cnt`=0.
- Stuff chain: 0×5 then 1×4 -> 0×5,1(stuff),1,1,1,1,0(stuff). The stuff bit starts the run.
- `in_valid` held low -> `can_tx`=1, `bit_strobe` every 8 cycles, `in_ready` pulses on each tick.
- Assert `rst_n`=0 during a stuff bit -> next edge `can_tx`=1, `stuff_pend` cleared. After release, 0×4 produces no stuff.

Source files
------------

// File: rtl/can_pkg.sv
// Shared CAN definitions: line levels, stuffing run length, default bit
// period and the stuffer state encoding. Also used by the future RX sampler.
package can_pkg;

  // Line levels: a 0 on the bus overrides (dominates) a 1.
  localparam logic CAN_RECESSIVE = 1'b1;
  localparam logic CAN_DOMINANT  = 1'b0;

  // Number of identical bits after which a complementary bit is inserted.
  localparam int unsigned CAN_STUFF_RUN = 5;

  // 500 kbit/s from a 50 MHz system clock.
  localparam int unsigned CAN_BIT_PERIOD_DEF = 100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    STUFF = 2'd2
  } stuff_state_t;

  // Run length after putting bit b on the line, given the previous line bit
  // and run. A run of 0 means the previous bit was outside the stuffed
  // region, so the new bit always opens a fresh run.
  function automatic logic [2:0] next_run(input logic [2:0] run,
                                          input logic       b,
                                          input logic       last);
    if ((b == last) && (run != 3'd0))
      return run + 3'd1;
    else
      return 3'd1;
  endfunction

endpackage

// File: rtl/can_bit_timer.sv
// Free-running bit-time prescaler. Counts 0..PERIOD-1 and flags the last
// cycle of each bit time with tick. The sync input restarts the bit time
// (hard synchronisation for the receive sampler); the transmitter ties it low.
module can_bit_timer
  import can_pkg::*;
#(
  parameter int unsigned PERIOD = CAN_BIT_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync,
  output logic tick
);

  localparam int unsigned W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] cnt;

  // Prescaler: wrap on the last cycle of the bit, restart on sync.
  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (sync || (cnt == LAST))
      cnt <= '0;
    else
      cnt <= cnt + W'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/can_bit_stuffer.sv
// CAN TX bit stuffer. Takes raw frame bits over a valid/ready handshake,
// paces them onto can_tx at one bit per BIT_PERIOD clocks and inserts a
// complementary bit after five identical bits inside the stuffed region.
// Optional build macro CAN_STUFF_STATS_EN enables the stuff_cnt counter;
// without it stuff_cnt reads 0.
module can_bit_stuffer
  import can_pkg::*;
#(
  parameter int unsigned BIT_PERIOD = CAN_BIT_PERIOD_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_bit,
  input  logic       in_stuff_en,
  output logic       in_ready,
  output logic       can_tx,
  output logic       bit_strobe,
  output logic       stuff_flag,
  output logic [7:0] stuff_cnt
);

  stuff_state_t state;
  logic         tick;
  logic         last_bit;
  logic [2:0]   run;
  logic [2:0]   run_nxt;
  logic         stuff_pend;

  can_bit_timer #(.PERIOD(BIT_PERIOD)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .sync  (1'b0),
    .tick  (tick)
  );

  // Upstream may only hand over a bit on a boundary that is not owed to a
  // stuff bit. Gated by rst_n so the port reads 0 throughout reset.
  assign in_ready = rst_n & tick & ~stuff_pend;

  assign run_nxt    = next_run(run, in_bit, last_bit);
  assign stuff_flag = (state == STUFF);

  // Line FSM: one line update per tick; owed stuff bit beats new input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      can_tx     <= CAN_RECESSIVE;
      bit_strobe <= 1'b0;
      last_bit   <= CAN_RECESSIVE;
      run        <= 3'd0;
      stuff_pend <= 1'b0;
    end else begin
      bit_strobe <= tick;
      if (tick) begin
        if (stuff_pend) begin
          // Stuff bit opens a new run of its own value.
          can_tx     <= ~last_bit;
          last_bit   <= ~last_bit;
          run        <= 3'd1;
          stuff_pend <= 1'b0;
          state      <= STUFF;
        end else if (in_valid) begin
          can_tx   <= in_bit;
          last_bit <= in_bit;
          state    <= DATA;
          if (in_stuff_en) begin
            run        <= run_nxt;
            stuff_pend <= (run_nxt == 3'(CAN_STUFF_RUN));
          end else begin
            run <= 3'd0;
          end
        end else begin
          can_tx   <= CAN_RECESSIVE;
          last_bit <= CAN_RECESSIVE;
          run      <= 3'd0;
          state    <= IDLE;
        end
      end
    end
  end

`ifdef CAN_STUFF_STATS_EN
  logic [7:0] cnt_q;

  // Saturating count of inserted stuff bits, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_q <= 8'd0;
    else if (tick && stuff_pend && (cnt_q != 8'hFF))
      cnt_q <= cnt_q + 8'd1;
  end

  assign stuff_cnt = cnt_q;
`else
  assign stuff_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_can_bit_stuffer.sv
// Bench for can_bit_stuffer: directed vector table, reset-in-frame
// sequences, and randomized streams against a line-history model.
module tb_can_bit_stuffer;

  localparam int BP = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_stuff_en = 1'b0;
  logic       in_ready;
  logic       can_tx;
  logic       bit_strobe;
  logic       stuff_flag;
  logic [7:0] stuff_cnt;

  int checks = 0;
  int failures = 0;

  can_bit_stuffer #(.BIT_PERIOD(BP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .in_stuff_en (in_stuff_en),
    .in_ready    (in_ready),
    .can_tx      (can_tx),
    .bit_strobe  (bit_strobe),
    .stuff_flag  (stuff_flag),
    .stuff_cnt   (stuff_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_cnt(input int n);
`ifdef CAN_STUFF_STATS_EN
    return (n > 255) ? 8'hFF : 8'(n);
`else
    return 8'd0;
`endif
  endfunction

  // Line history model: every emitted bit with a flag saying whether it
  // belongs to the stuffed region (stuff-enabled data bits and stuff bits).
  // A stuff bit is owed when the last five line bits are all stuffed-region
  // bits of the same value.
  typedef struct { logic b; logic f; } hist_t;
  hist_t hist[$];
  int    model_stuffs;

  function automatic logic owed();
    int n = hist.size();
    if (n < 5) return 1'b0;
    for (int i = n - 5; i < n; i++)
      if (!hist[i].f || (hist[i].b !== hist[n-1].b)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic last_line();
    return (hist.size() == 0) ? 1'b1 : hist[hist.size()-1].b;
  endfunction

  function automatic void push(input logic b, input logic f);
    hist_t h;
    h.b = b;
    h.f = f;
    hist.push_back(h);
    if (hist.size() > 8) void'(hist.pop_front());
  endfunction

  // Reset and check reset values; leaves the bench at the negedge where
  // rst_n is released, i.e. the start of the first bit slot.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset can_tx", can_tx, 1);
    chk("reset strobe/ready/flag", {bit_strobe, in_ready, stuff_flag}, 0);
    chk("reset stuff_cnt", stuff_cnt, 0);
    rst_n = 1'b1;
    hist.delete();
    model_stuffs = 0;
  endtask

  // One bit slot: offer inputs, check the line holds, check in_ready on the
  // tick cycle, then check the new line bit and strobe.
  task automatic slot(input logic v, input logic b, input logic e,
                      input logic exp_rdy, input logic exp_tx, input logic exp_sf,
                      input string nm);
    logic prev;
    bit   hold_ok;
    in_valid = v;
    in_bit = b;
    in_stuff_en = e;
    prev = can_tx;
    hold_ok = 1'b1;
    repeat (BP - 2) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || bit_strobe !== 1'b0 || can_tx !== prev) hold_ok = 1'b0;
    end
    @(negedge clk);
    if (bit_strobe !== 1'b0 || can_tx !== prev) hold_ok = 1'b0;
    chk({nm, " hold"}, 32'(hold_ok), 1);
    chk({nm, " in_ready"}, in_ready, exp_rdy);
    @(negedge clk);
    chk({nm, " can_tx"}, can_tx, exp_tx);
    chk({nm, " strobe"}, bit_strobe, 1);
    chk({nm, " stuff_flag"}, stuff_flag, exp_sf);
  endtask

  // Slot whose expectations come from the history model.
  task automatic model_slot(input logic v, input logic b, input logic e, input string nm);
    logic last;
    last = last_line();
    if (owed()) begin
      slot(v, b, e, 1'b0, ~last, 1'b1, nm);
      push(~last, 1'b1);
      model_stuffs++;
    end else if (v) begin
      slot(v, b, e, 1'b1, b, 1'b0, nm);
      push(b, e);
    end else begin
      slot(1'b0, b, e, 1'b1, 1'b1, 1'b0, nm);
      push(1'b1, 1'b0);
    end
  endtask

  typedef struct {
    int          n_in;
    logic [15:0] bits;
    logic        en;
    int          n_line;
    logic [15:0] line;
    logic [15:0] smask;
    int          nstuff;
  } vec_t;

  vec_t vt[5];

  initial begin
    // bit i of bits/line/smask is the i-th input bit / line slot
    vt[0] = '{n_in: 6,  bits: 16'h0020, en: 1'b1, n_line: 7,  line: 16'h0060, smask: 16'h0020, nstuff: 1};
    vt[1] = '{n_in: 10, bits: 16'h03FF, en: 1'b1, n_line: 13, line: 16'h17DF, smask: 16'h0820, nstuff: 2};
    vt[2] = '{n_in: 7,  bits: 16'h0000, en: 1'b0, n_line: 8,  line: 16'h0080, smask: 16'h0000, nstuff: 0};
    vt[3] = '{n_in: 9,  bits: 16'h01E0, en: 1'b1, n_line: 12, line: 16'h0BE0, smask: 16'h0420, nstuff: 2};
    vt[4] = '{n_in: 0,  bits: 16'h0000, en: 1'b1, n_line: 3,  line: 16'h0007, smask: 16'h0000, nstuff: 0};

    // Directed vectors
    for (int v = 0; v < 5; v++) begin
      int    idx;
      logic  offer;
      string nm;
      do_reset();
      idx = 0;
      for (int s = 0; s < vt[v].n_line; s++) begin
        nm = $sformatf("vec%0d slot%0d", v, s);
        offer = (idx < vt[v].n_in);
        if (vt[v].smask[s]) begin
          slot(offer, vt[v].bits[idx], vt[v].en, 1'b0, vt[v].line[s], 1'b1, nm);
        end else begin
          slot(offer, offer ? vt[v].bits[idx] : 1'b0, vt[v].en, 1'b1, vt[v].line[s], 1'b0, nm);
          if (offer) idx++;
        end
      end
      chk($sformatf("vec%0d consumed", v), idx, vt[v].n_in);
      chk($sformatf("vec%0d stuff_cnt", v), stuff_cnt, exp_cnt(vt[v].nstuff));
    end

    // Reset while a stuff bit is owed (variant 0) or on the line (variant 1)
    for (int k = 0; k < 2; k++) begin
      string nm;
      nm = $sformatf("rst%0d", k);
      do_reset();
      for (int i = 0; i < 5; i++) slot(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, nm);
      if (k == 1) slot(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, {nm, " stuff"});
      @(negedge clk);
      @(negedge clk);
      chk({nm, " pre can_tx"}, can_tx, (k == 1) ? 1 : 0);
      rst_n = 1'b0;
      @(negedge clk);
      chk({nm, " mid can_tx"}, can_tx, 1);
      chk({nm, " mid flag/strobe/ready"}, {stuff_flag, bit_strobe, in_ready}, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) slot(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, {nm, " after"});
      slot(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, {nm, " idle"});
      chk({nm, " stuff_cnt"}, stuff_cnt, 0);
    end

    // Randomized streams with runs, gaps and region changes
    do_reset();
    begin
      logic pb = 1'b0;
      for (int i = 0; i < 400; i++) begin
        logic v, b, e;
        v  = ($urandom % 5) != 0;
        b  = (($urandom % 4) == 0) ? ~pb : pb;
        pb = b;
        e  = ($urandom % 6) != 0;
        model_slot(v, b, e, "rnd");
      end
    end
    chk("rnd stuff_cnt", stuff_cnt, exp_cnt(model_stuffs));

    // Long constant stream: drives the counter into saturation
    for (int i = 0; i < 1600; i++) model_slot(1'b1, 1'b0, 1'b1, "sat");
    chk("sat stuff_cnt", stuff_cnt, exp_cnt(model_stuffs));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
